// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int unsigned DEF_REG_ADDR_W      = 4;
  localparam int unsigned DEF_LOAD_USE_CYCLES = 1;
  localparam int unsigned DEF_STALL_CNT_W     = 16;

endpackage

// File: rtl/hazard_raw_compare.sv
// RAW detector for one producer stage: does the ID instruction read what this stage writes back?
module hazard_raw_compare
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  wb_en,
  output logic                  raw
);

  always_comb begin
    raw = wb_en & ((src1 == dest) | (two_src & (src2 == dest)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard unit for the 5-stage pipeline: RAW/load-use stalls, SRAM-wait freeze
// and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = DEF_REG_ADDR_W,
  parameter int unsigned LOAD_USE_CYCLES = DEF_LOAD_USE_CYCLES,
  parameter int unsigned STALL_CNT_W     = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fwd_en,
  input  logic [REG_ADDR_W-1:0]  src1,
  input  logic [REG_ADDR_W-1:0]  src2,
  input  logic                   two_src,
  input  logic [REG_ADDR_W-1:0]  exe_dest,
  input  logic                   exe_wb_en,
  input  logic                   exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0]  mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  input  logic                   cnt_clr,
  output logic                   hazard,
  output logic                   freeze,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int unsigned LU_W = (LOAD_USE_CYCLES > 2) ? $clog2(LOAD_USE_CYCLES) : 1;
  localparam bit          MULTI_LU = (LOAD_USE_CYCLES > 1);
  localparam logic [LU_W-1:0] LU_INIT = LU_W'(MULTI_LU ? LOAD_USE_CYCLES - 2 : 0);

  logic raw_exe;
  logic raw_mem;
  logic hit;
  logic sram_wait;

  state_e state_q, state_d;
  state_e ret_q, ret_d;
  logic [LU_W-1:0]        lu_cnt_q, lu_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  hazard_raw_compare #(.REG_ADDR_W(REG_ADDR_W)) u_raw_exe (
    .src1    (src1),
    .src2    (src2),
    .two_src (two_src),
    .dest    (exe_dest),
    .wb_en   (exe_wb_en),
    .raw     (raw_exe)
  );

  hazard_raw_compare #(.REG_ADDR_W(REG_ADDR_W)) u_raw_mem (
    .src1    (src1),
    .src2    (src2),
    .two_src (two_src),
    .dest    (mem_dest),
    .wb_en   (mem_wb_en),
    .raw     (raw_mem)
  );

  // An SRAM wait arriving during a load-use bubble freezes that cycle too, so the
  // bubble is not consumed and lu_cnt can be held across the wait.
  always_comb begin
    hit       = fwd_en ? (raw_exe & exe_mem_r_en) : (raw_exe | raw_mem);
    sram_wait = mem_req & ~mem_ready;
    freeze    = ~rst & (((state_q == MEM_WAIT) & ~mem_ready) |
                        ((state_q != MEM_WAIT) & sram_wait));
    hazard    = ~rst & ~freeze & (((state_q == RUN) & hit) | (state_q == LU_STALL));
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    lu_cnt_d = lu_cnt_q;
    case (state_q)
      RUN: begin
        if (sram_wait) begin
          state_d = MEM_WAIT;
          ret_d   = RUN;
        end else if (hit & fwd_en & MULTI_LU) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_INIT;
        end
      end
      LU_STALL: begin
        if (sram_wait) begin
          state_d = MEM_WAIT;
          ret_d   = LU_STALL;
        end else if (lu_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          lu_cnt_d = lu_cnt_q - LU_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ret_q;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (cnt_clr) begin
      stall_count_d = '0;
    end else if ((hazard | freeze) & ~(&stall_count_q)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ret_q         <= RUN;
      lu_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      lu_cnt_q      <= lu_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
